// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared integer register-file types and constants for the
//                writeback path (result entry layout, widths).
//  Revision    : 1.0  initial release
// ============================================================================
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    // One register-file write: destination index plus result value.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_fifo
//  Description : Synchronous FIFO of writeback entries. Head is presented
//                combinationally; a push is only visible at the head from the
//                cycle after it is written (no bypass).
//  Revision    : 1.0  initial release
// ============================================================================
module wb_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  wb_entry_t                  push_entry,
    input  logic                       pop,
    output wb_entry_t                  head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t          r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_do_push;
    logic               w_do_pop;

    // Qualify requests so a misbehaving caller can never corrupt the pointers.
    always_comb begin
        w_do_push = push && (r_count != CNT_W'(DEPTH));
        w_do_pop  = pop  && (r_count != '0);
    end

    // Storage array; write only, contents need no reset since count gates use.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_entry;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is 2^n.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Status and head outputs, all derived from registered state.
    always_comb begin
        head  = r_mem[r_rd_ptr];
        count = r_count;
        full  = (r_count == CNT_W'(DEPTH));
        empty = (r_count == '0);
    end

endmodule : wb_fifo
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter
//  Description : Merges the in-order writeback (A) and the buffered multi-cycle
//                unit results (B) onto the single register-file write port,
//                with a starvation guard for B and a pending-write scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_arbiter
    import riscv_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic [REG_ADDR_W-1:0]   a_rd,
    input  logic [XLEN-1:0]         a_data,
    input  logic                    b_valid,
    output logic                    b_ready,
    input  logic [REG_ADDR_W-1:0]   b_rd,
    input  logic [XLEN-1:0]         b_data,
    input  logic                    b_issue,
    input  logic [REG_ADDR_W-1:0]   b_issue_rd,
    output logic                    rf_we,
    output logic [REG_ADDR_W-1:0]   rf_rd,
    output logic [XLEN-1:0]         rf_wdata,
    output logic [NUM_REGS-1:0]     busy
);

    localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    // FIFO interface
    wb_entry_t              w_push_entry;
    wb_entry_t              w_head;
    logic [CNT_W-1:0]       w_fifo_count;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic                   w_push;
    logic                   w_pop;

    // Arbitration
    logic [STARVE_W-1:0]    r_starve;
    logic                   w_force_b;
    logic                   w_sel_a;
    logic                   w_sel_valid;
    wb_entry_t              w_sel_entry;

    // Output register and scoreboard
    logic                   r_rf_we;
    logic [REG_ADDR_W-1:0]  r_rf_rd;
    logic [XLEN-1:0]        r_rf_wdata;
    logic [NUM_REGS-1:0]    r_busy;
    logic [NUM_REGS-1:0]    w_busy_next;

    wb_fifo #(
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (w_push),
        .push_entry (w_push_entry),
        .pop        (w_pop),
        .head       (w_head),
        .count      (w_fifo_count),
        .full       (w_fifo_full),
        .empty      (w_fifo_empty)
    );

    // B acceptance: ready comes only from the registered occupancy.
    always_comb begin
        b_ready           = (w_fifo_count < CNT_W'(FIFO_DEPTH));
        w_push            = b_valid && !w_fifo_full;
        w_push_entry.rd   = b_rd;
        w_push_entry.data = b_data;
    end

    // Per-cycle selection: forced B drain, else A, else idle-slot B drain.
    always_comb begin
        w_force_b   = (r_starve == STARVE_W'(STARVE_LIMIT)) && !w_fifo_empty;
        a_ready     = !w_force_b;
        w_sel_a     = a_valid && !w_force_b;
        w_pop       = !w_fifo_empty && !w_sel_a;
        w_sel_valid = w_sel_a || w_pop;
        if (w_sel_a) begin
            w_sel_entry.rd   = a_rd;
            w_sel_entry.data = a_data;
        end else begin
            w_sel_entry = w_head;
        end
    end

    // Starvation counter: counts A wins while B is waiting, cleared by any drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= '0;
        end else if (w_pop || w_fifo_empty) begin
            r_starve <= '0;
        end else if (w_sel_a) begin
            r_starve <= r_starve + STARVE_W'(1);
        end
    end

    // Write-port register; address/data hold when no write is produced.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rf_we    <= 1'b0;
            r_rf_rd    <= '0;
            r_rf_wdata <= '0;
        end else if (w_sel_valid && (w_sel_entry.rd != '0)) begin
            r_rf_we    <= 1'b1;
            r_rf_rd    <= w_sel_entry.rd;
            r_rf_wdata <= w_sel_entry.data;
        end else begin
            r_rf_we    <= 1'b0;
        end
    end

    // Scoreboard next state: clear on B drain, then set on issue so a fresh
    // issue to the same register supersedes the completing one.
    always_comb begin
        w_busy_next = r_busy;
        if (w_pop) begin
            w_busy_next[w_head.rd] = 1'b0;
        end
        if (b_issue) begin
            w_busy_next[b_issue_rd] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    // Output assignments.
    always_comb begin
        rf_we    = r_rf_we;
        rf_rd    = r_rf_rd;
        rf_wdata = r_rf_wdata;
        busy     = r_busy;
    end

endmodule : wb_arbiter
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_arbiter
//  Description : Directed self-checking bench for wb_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_rd;
    logic [31:0] b_data;
    logic        b_issue;
    logic [4:0]  b_issue_rd;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic [31:0] busy;

    int checks;
    int errors;

    wb_arbiter #(
        .FIFO_DEPTH   (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_rd       (a_rd),
        .a_data     (a_data),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_rd       (b_rd),
        .b_data     (b_data),
        .b_issue    (b_issue),
        .b_issue_rd (b_issue_rd),
        .rf_we      (rf_we),
        .rf_rd      (rf_rd),
        .rf_wdata   (rf_wdata),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; afterwards registered outputs reflect that edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_valid    = 1'b0;
        a_rd       = '0;
        a_data     = '0;
        b_valid    = 1'b0;
        b_rd       = '0;
        b_data     = '0;
        b_issue    = 1'b0;
        b_issue_rd = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (rf_we !== 1'b0)     begin errors++; $display("FAIL reset_rf_we got %0b exp 0", rf_we); end
        checks++; if (rf_rd !== 5'd0)     begin errors++; $display("FAIL reset_rf_rd got %0d exp 0", rf_rd); end
        checks++; if (rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_rf_wdata got %h exp 0", rf_wdata); end
        checks++; if (busy !== 32'd0)     begin errors++; $display("FAIL reset_busy got %h exp 0", busy); end
        checks++; if (a_ready !== 1'b1)   begin errors++; $display("FAIL reset_a_ready got %0b exp 1", a_ready); end
        checks++; if (b_ready !== 1'b1)   begin errors++; $display("FAIL reset_b_ready got %0b exp 1", b_ready); end
    endtask

    task automatic test_a_write();
        a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
        tick();
        a_valid = 1'b0;
        checks++; if (rf_we !== 1'b1)           begin errors++; $display("FAIL a_we got %0b exp 1", rf_we); end
        checks++; if (rf_rd !== 5'd5)           begin errors++; $display("FAIL a_rd got %0d exp 5", rf_rd); end
        checks++; if (rf_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL a_data got %h exp deadbeef", rf_wdata); end
        tick();
        checks++; if (rf_we !== 1'b0)           begin errors++; $display("FAIL a_we_drop got %0b exp 0", rf_we); end
        checks++; if (rf_rd !== 5'd5)           begin errors++; $display("FAIL a_rd_hold got %0d exp 5", rf_rd); end
    endtask

    task automatic test_b_idle();
        b_issue = 1'b1; b_issue_rd = 5'd7;
        tick();
        b_issue = 1'b0;
        checks++; if (busy !== 32'h0000_0080) begin errors++; $display("FAIL b_issue_busy got %h exp 00000080", busy); end
        b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h1234;
        tick();
        b_valid = 1'b0;
        checks++; if (rf_we !== 1'b0)         begin errors++; $display("FAIL b_no_bypass got %0b exp 0", rf_we); end
        checks++; if (busy[7] !== 1'b1)       begin errors++; $display("FAIL b_busy_pending got %0b exp 1", busy[7]); end
        tick();
        checks++; if (rf_we !== 1'b1)         begin errors++; $display("FAIL b_we got %0b exp 1", rf_we); end
        checks++; if (rf_rd !== 5'd7)         begin errors++; $display("FAIL b_rd got %0d exp 7", rf_rd); end
        checks++; if (rf_wdata !== 32'h1234)  begin errors++; $display("FAIL b_data got %h exp 1234", rf_wdata); end
        checks++; if (busy !== 32'd0)         begin errors++; $display("FAIL b_busy_clear got %h exp 0", busy); end
        tick();
        checks++; if (rf_we !== 1'b0)         begin errors++; $display("FAIL b_we_drop got %0b exp 0", rf_we); end
    endtask

    // FIFO fills while A is busy, then the starvation guard forces a drain.
    task automatic test_full_and_starve();
        a_valid = 1'b1; a_rd = 5'd1; a_data = 32'hA1;
        b_valid = 1'b1; b_rd = 5'd9; b_data = 32'hB9;
        b_issue = 1'b1; b_issue_rd = 5'd9;
        tick();
        checks++; if (rf_rd !== 5'd1 || rf_wdata !== 32'hA1) begin errors++; $display("FAIL full_a1 got rd %0d data %h exp rd 1 data a1", rf_rd, rf_wdata); end
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL full_ready1 got %0b exp 1", b_ready); end
        a_rd = 5'd2; a_data = 32'hA2;
        b_rd = 5'd10; b_data = 32'hB10;
        b_issue_rd = 5'd10;
        tick();
        b_valid = 1'b0; b_issue = 1'b0;
        checks++; if (rf_rd !== 5'd2 || rf_we !== 1'b1) begin errors++; $display("FAIL full_a2 got rd %0d we %0b exp rd 2 we 1", rf_rd, rf_we); end
        checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL full_not_ready got %0b exp 0", b_ready); end
        checks++; if (busy !== 32'h0000_0600) begin errors++; $display("FAIL full_busy got %h exp 00000600", busy); end
        for (int k = 3; k <= 4; k++) begin
            a_rd = 5'(k); a_data = 32'hA0 + 32'(k);
            tick();
            checks++; if (a_ready !== 1'b1 || rf_rd !== 5'(k)) begin errors++; $display("FAIL starve_win%0d got a_ready %0b rd %0d exp 1 %0d", k, a_ready, rf_rd, k); end
        end
        a_rd = 5'd5; a_data = 32'hA5;
        tick();
        checks++; if (rf_rd !== 5'd5 || rf_wdata !== 32'hA5) begin errors++; $display("FAIL starve_a5 got rd %0d data %h exp 5 a5", rf_rd, rf_wdata); end
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL starve_block got %0b exp 0", a_ready); end
        a_rd = 5'd6; a_data = 32'hA6;
        tick();
        checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd9 || rf_wdata !== 32'hB9) begin errors++; $display("FAIL starve_drain got we %0b rd %0d data %h exp 1 9 b9", rf_we, rf_rd, rf_wdata); end
        checks++; if (busy !== 32'h0000_0400) begin errors++; $display("FAIL starve_busy got %h exp 00000400", busy); end
        checks++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin errors++; $display("FAIL starve_release got a %0b b %0b exp 1 1", a_ready, b_ready); end
        tick();
        a_valid = 1'b0;
        checks++; if (rf_rd !== 5'd6 || rf_wdata !== 32'hA6) begin errors++; $display("FAIL starve_a6 got rd %0d data %h exp 6 a6", rf_rd, rf_wdata); end
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL starve_cleared got %0b exp 1", a_ready); end
        tick();
        checks++; if (rf_rd !== 5'd10 || rf_wdata !== 32'hB10 || rf_we !== 1'b1) begin errors++; $display("FAIL drain_b10 got rd %0d data %h we %0b exp 10 b10 1", rf_rd, rf_wdata, rf_we); end
        checks++; if (busy !== 32'd0) begin errors++; $display("FAIL drain_busy got %h exp 0", busy); end
        tick();
    endtask

    task automatic test_x0();
        a_valid = 1'b1; a_rd = 5'd0; a_data = 32'h55;
        tick();
        a_valid = 1'b0;
        checks++; if (rf_we !== 1'b0 || rf_rd !== 5'd10) begin errors++; $display("FAIL x0_a got we %0b rd %0d exp 0 10", rf_we, rf_rd); end
        b_issue = 1'b1; b_issue_rd = 5'd0;
        b_valid = 1'b1; b_rd = 5'd0; b_data = 32'h66;
        tick();
        b_issue = 1'b0; b_valid = 1'b0;
        checks++; if (busy !== 32'd0) begin errors++; $display("FAIL x0_busy got %h exp 0", busy); end
        tick();
        checks++; if (rf_we !== 1'b0 || rf_wdata !== 32'hB10) begin errors++; $display("FAIL x0_b got we %0b data %h exp 0 b10", rf_we, rf_wdata); end
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL x0_consumed got %0b exp 1", b_ready); end
    endtask

    task automatic test_set_clear_and_reset();
        b_issue = 1'b1; b_issue_rd = 5'd3;
        tick();
        b_issue = 1'b0;
        b_valid = 1'b1; b_rd = 5'd3; b_data = 32'h33;
        tick();
        b_valid = 1'b0;
        b_issue = 1'b1; b_issue_rd = 5'd3;
        tick();
        b_issue = 1'b0;
        checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd3 || rf_wdata !== 32'h33) begin errors++; $display("FAIL sc_write got we %0b rd %0d data %h exp 1 3 33", rf_we, rf_rd, rf_wdata); end
        checks++; if (busy !== 32'h0000_0008) begin errors++; $display("FAIL sc_busy got %h exp 00000008", busy); end
        a_valid = 1'b1; a_rd = 5'd1; a_data = 32'h11;
        b_valid = 1'b1; b_rd = 5'd4; b_data = 32'h44;
        b_issue = 1'b1; b_issue_rd = 5'd4;
        tick();
        b_rd = 5'd5; b_data = 32'h45; b_issue_rd = 5'd5;
        tick();
        b_valid = 1'b0; b_issue = 1'b0; a_valid = 1'b0;
        checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL rst_prefull got %0b exp 0", b_ready); end
        checks++; if (busy !== 32'h0000_0038) begin errors++; $display("FAIL rst_prebusy got %h exp 00000038", busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy !== 32'd0)   begin errors++; $display("FAIL rst_busy got %h exp 0", busy); end
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL rst_b_ready got %0b exp 1", b_ready); end
        checks++; if (rf_we !== 1'b0)   begin errors++; $display("FAIL rst_rf_we got %0b exp 0", rf_we); end
        tick();
        checks++; if (rf_we !== 1'b0)   begin errors++; $display("FAIL rst_discard got %0b exp 0", rf_we); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle_inputs();
        test_reset();
        test_a_write();
        test_b_idle();
        test_full_and_starve();
        test_x0();
        test_set_clear_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_wb_arbiter
`default_nettype wire
